// File: rtl/pe_bram_pkg.sv
//------------------------------------------------------------------------------
// Module   : pe_bram_pkg
// Purpose  : Shared state encoding, sizing helpers and skid-beat type for the
//            PE array BRAM host.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pe_bram_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  // Matrix (VS*VS words) followed by the vector (VS words).
  function automatic int calc_depth(input int vector_size);
    return vector_size * (vector_size + 1);
  endfunction

  function automatic int calc_aw(input int l_ram_size);
    return 2 * l_ram_size + 1;
  endfunction

  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

endpackage

`default_nettype wire

// File: rtl/pe_bram_tdp.sv
//------------------------------------------------------------------------------
// Module   : pe_bram_tdp
// Purpose  : True dual-port word RAM. Port A has byte enables and read-first
//            behaviour; port B does whole-word writes. Both reads take 1 cycle
//            and return 0 for indices beyond DEPTH-1.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pe_bram_tdp #(
  parameter int DEPTH = 4160,
  parameter int AW    = 13
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [AW-1:0] a_addr,
  input  logic [3:0]    a_we,
  input  logic [31:0]   a_wdata,
  output logic [31:0]   a_rdata,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  input  logic [31:0]   b_wdata,
  output logic [31:0]   b_rdata
);

  localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

  logic [31:0] r_mem [0:DEPTH-1];
  logic [31:0] r_a_rdata;
  logic [31:0] r_b_rdata;
  logic        w_a_in;
  logic        w_b_in;

  assign w_a_in = (a_addr <= C_LAST);
  assign w_b_in = (b_addr <= C_LAST);

  always_ff @(posedge aclk) begin
    if (w_a_in) begin
      for (int i = 0; i < 4; i++) begin
        if (a_we[i]) r_mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
    if (b_we && w_b_in) r_mem[b_addr] <= b_wdata;
  end

  // Non-blocking reads sample the array before this edge's writes land.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_a_rdata <= w_a_in ? r_mem[a_addr] : '0;
      r_b_rdata <= w_b_in ? r_mem[b_addr] : '0;
    end
  end

  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;

endmodule

`default_nettype wire

// File: rtl/pe_bram_host.sv
//------------------------------------------------------------------------------
// Module   : pe_bram_host
// Purpose  : BRAM responder and host sequencer for the PE array controller:
//            fills operands, kicks the controller, drains the result vector.
//            Optional RUN watchdog enabled by PE_BRAM_HOST_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pe_bram_host
  import pe_bram_pkg::*;
#(
  parameter int VECTOR_SIZE    = 64,
  parameter int L_RAM_SIZE     = 6,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic        err,
  output logic        pe_start,
  input  logic        pe_done,
  input  logic [31:0] bram_addr,
  input  logic [31:0] bram_wrdata,
  input  logic [3:0]  bram_we,
  output logic [31:0] bram_rddata
);

  localparam int DEPTH = calc_depth(VECTOR_SIZE);
  localparam int AW    = calc_aw(L_RAM_SIZE);
  localparam int RW    = L_RAM_SIZE + 1;

  localparam logic [AW-1:0] C_WR_LAST = AW'(DEPTH - 1);
  localparam logic [RW-1:0] C_RD_END  = RW'(VECTOR_SIZE);
  localparam logic [RW-1:0] C_RD_LAST = RW'(VECTOR_SIZE - 1);

  logic [2:0]    r_state;
  logic [2:0]    w_state_nx;
  logic [AW-1:0] r_wr_ptr;
  logic [RW-1:0] r_rd_ptr;
  logic          r_s_ready;
  logic          r_pend;
  logic          r_pend_last;
  beat_t         r_skid [2];
  logic          r_head;
  logic          r_tail;
  logic [1:0]    r_cnt;

  logic          w_drain;
  logic          w_s_fire;
  logic          w_m_fire;
  logic          w_last_fire;
  logic          w_issue;
  logic [2:0]    w_occ;
  logic          w_timeout;
  logic [AW-1:0] w_a_addr;
  logic [3:0]    w_a_we;
  logic [AW-1:0] w_b_addr;
  logic [31:0]   w_b_rdata;

  assign w_drain     = (r_state == ST_DRAIN);
  assign w_s_fire    = s_valid && r_s_ready;
  assign m_valid     = w_drain && (r_cnt != 2'd0);
  assign m_data      = r_skid[r_head].data;
  assign m_last      = m_valid && r_skid[r_head].last;
  assign w_m_fire    = m_valid && m_ready;
  assign w_last_fire = w_m_fire && m_last;

  // Words already buffered plus the read in flight must leave room for one more.
  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_m_fire};
  assign w_issue = w_drain && (r_rd_ptr != C_RD_END) && (w_occ < 3'd2);

  assign s_ready  = r_s_ready;
  assign busy     = (r_state != ST_IDLE);
  assign pe_start = (r_state == ST_START);

  assign w_a_addr = AW'(word_index(bram_addr));
  assign w_a_we   = (r_state == ST_RUN) ? bram_we : 4'b0000;
  assign w_b_addr = w_drain ? AW'(r_rd_ptr) : r_wr_ptr;

  pe_bram_tdp #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .aclk    (aclk),
    .aresetn (aresetn),
    .a_addr  (w_a_addr),
    .a_we    (w_a_we),
    .a_wdata (bram_wrdata),
    .a_rdata (bram_rddata),
    .b_addr  (w_b_addr),
    .b_we    (w_s_fire),
    .b_wdata (s_data),
    .b_rdata (w_b_rdata)
  );

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (w_s_fire) w_state_nx = ST_FILL;
      ST_FILL:  if (w_s_fire && (r_wr_ptr == C_WR_LAST)) w_state_nx = ST_START;
      ST_START: w_state_nx = ST_RUN;
      ST_RUN: begin
        if (pe_done)        w_state_nx = ST_DRAIN;
        else if (w_timeout) w_state_nx = ST_IDLE;
      end
      ST_DRAIN: if (w_last_fire) w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_s_ready   <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
      r_cnt       <= 2'd0;
      r_skid[0]   <= '0;
      r_skid[1]   <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_s_ready <= (w_state_nx == ST_IDLE) || (w_state_nx == ST_FILL);

      if (w_s_fire) r_wr_ptr <= (r_wr_ptr == C_WR_LAST) ? '0 : r_wr_ptr + 1'b1;

      if (w_last_fire) begin
        r_rd_ptr <= '0;
        r_pend   <= 1'b0;
        r_head   <= 1'b0;
        r_tail   <= 1'b0;
        r_cnt    <= 2'd0;
      end else begin
        if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_pend      <= w_issue;
        r_pend_last <= (r_rd_ptr == C_RD_LAST);
        if (r_pend) begin
          r_skid[r_tail] <= '{last: r_pend_last, data: w_b_rdata};
          r_tail         <= ~r_tail;
        end
        if (w_m_fire) r_head <= ~r_head;
        r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_m_fire};
      end
    end
  end

`ifdef PE_BRAM_HOST_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_err;

  // The counter sits at 0 outside RUN, so it is cleared on every entry.
  assign w_timeout = (r_state == ST_RUN) && !pe_done && (r_tmo_cnt == C_TMO_LAST);
  assign err       = r_err;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == ST_RUN) ? r_tmo_cnt + 1'b1 : '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe_bram_host.sv
//------------------------------------------------------------------------------
// Module   : tb_pe_bram_host
// Purpose  : Self-checking bench for pe_bram_host (VECTOR_SIZE=4, DEPTH=20).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pe_bram_host;

  localparam int VS    = 4;
  localparam int L     = 2;
  localparam int DEPTH = 20;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        busy;
  logic        err;
  logic        pe_start;
  logic        pe_done = 1'b0;
  logic [31:0] bram_addr = '0;
  logic [31:0] bram_wrdata = '0;
  logic [3:0]  bram_we = '0;
  logic [31:0] bram_rddata;

  int          n_total = 0;
  int          n_bad = 0;
  logic [31:0] model [DEPTH];
  logic [32:0] exp_q [$];

  always #5 aclk = ~aclk;

  pe_bram_host #(
    .VECTOR_SIZE    (VS),
    .L_RAM_SIZE     (L),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .busy        (busy),
    .err         (err),
    .pe_start    (pe_start),
    .pe_done     (pe_done),
    .bram_addr   (bram_addr),
    .bram_wrdata (bram_wrdata),
    .bram_we     (bram_we),
    .bram_rddata (bram_rddata)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Streams DEPTH words with an idle gap every few beats; pokes a BRAM write mid-fill.
  task automatic stream(input int base, input int mult);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge aclk);
      if (i % 7 == 3) begin
        s_valid = 1'b0;
        @(negedge aclk);
      end
      if (i == 5) begin
        bram_addr = 32'h0C; bram_we = 4'hF; bram_wrdata = 32'h0000_0BAD;
      end else begin
        bram_we = 4'h0;
      end
      s_valid = 1'b1;
      s_data  = 32'(base + i * mult);
      model[i] = s_data;
    end
    @(negedge aclk);
    s_valid = 1'b0;
  endtask

  task automatic bram_write(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
    @(negedge aclk);
    bram_addr = addr; bram_we = we; bram_wrdata = data;
    @(negedge aclk);
    bram_we = 4'h0;
  endtask

  task automatic bram_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge aclk);
    bram_addr = addr; bram_we = 4'h0;
    @(negedge aclk);
    check_val(tag, bram_rddata, exp);
  endtask

  task automatic pulse_done();
    @(negedge aclk);
    pe_done = 1'b1;
    for (int i = 0; i < VS; i++) exp_q.push_back({(i == VS - 1), model[i]});
    @(negedge aclk);
    pe_done = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    int beats = 0;
    int guard = 0;
    logic [32:0] e;
    while (beats < VS && guard < 100) begin
      @(negedge aclk);
      guard++;
      m_ready = toggle ? guard[0] : 1'b1;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_beat", 32'(beats), 32'(VS));
        end else begin
          e = exp_q.pop_front();
          check_val("m_data", m_data, e[31:0]);
          check_val("m_last", 32'(m_last), 32'(e[32]));
        end
        beats++;
      end
    end
    if (beats < VS) check_val("drain_timeout", 32'(beats), 32'(VS));
    @(negedge aclk);
    m_ready = 1'b0;
    check_val("busy_after_drain", 32'(busy), 32'd0);
    check_val("m_valid_after_drain", 32'(m_valid), 32'd0);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;

    #12;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_pe_start", 32'(pe_start), 32'd0);
    check_val("rst_rddata", bram_rddata, 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    // pe_done outside RUN must not move the FSM.
    @(negedge aclk);
    pe_done = 1'b1;
    @(negedge aclk);
    pe_done = 1'b0;
    check_val("idle_done_ignored", 32'(busy), 32'd0);
    check_val("idle_s_ready", 32'(s_ready), 32'd1);

    stream(0, 1);
    check_val("pe_start_pulse", 32'(pe_start), 32'd1);
    check_val("s_ready_start", 32'(s_ready), 32'd0);
    @(negedge aclk);
    check_val("pe_start_single", 32'(pe_start), 32'd0);
    check_val("busy_run", 32'(busy), 32'd1);

    bram_read("rd_word4", 32'h10, 32'd4);
    bram_read("rd_word3_fill_wr_ignored", 32'h0C, 32'd3);
    bram_read("rd_oob_word20", 32'h50, 32'd0);

    bram_write(32'h00, 4'hF, 32'hDEAD_BEEF);
    bram_write(32'h00, 4'h1, 32'h0000_0011);
    model[0] = 32'hDEAD_BE11;
    bram_read("rd_word0_bytes", 32'h00, 32'hDEAD_BE11);
    bram_write(32'h04, 4'b0110, 32'hAABB_CCDD);
    model[1] = 32'h00BB_CC01;
    bram_write(32'h08, 4'b1000, 32'h7700_0000);
    model[2] = 32'h7700_0002;
    bram_write(32'h50, 4'hF, 32'h1234_5678);
    bram_read("rd_word1_mid_lanes", 32'h04, 32'h00BB_CC01);
    bram_read("rd_oob_after_write", 32'h50, 32'd0);
    check_val("err_run", 32'(err), 32'd0);

    pulse_done();
    drain(1'b1);

    // Second job abandoned by reset while the first result is stalled.
    stream(100, 1);
    pulse_done();
    guard = 0;
    while (!m_valid && guard < 20) begin
      @(negedge aclk);
      guard++;
    end
    check_val("drain_valid_seen", 32'(m_valid), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check_val("async_rst_m_valid", 32'(m_valid), 32'd0);
    check_val("async_rst_busy", 32'(busy), 32'd0);
    check_val("async_rst_m_data", m_data, 32'd0);
    exp_q.delete();
    @(negedge aclk);
    aresetn = 1'b1;

    stream(0, 3);
    check_val("refill_pe_start", 32'(pe_start), 32'd1);
    bram_read("refill_word19", 32'h4C, 32'd57);
    pulse_done();
    drain(1'b0);

`ifdef PE_BRAM_HOST_TIMEOUT_EN
    stream(7, 2);
    check_val("tmo_pe_start", 32'(pe_start), 32'd1);
    repeat (100) @(negedge aclk);
    check_val("tmo_err_early", 32'(err), 32'd0);
    @(negedge aclk);
    check_val("tmo_err_set", 32'(err), 32'd1);
    check_val("tmo_busy", 32'(busy), 32'd0);
    check_val("tmo_s_ready", 32'(s_ready), 32'd1);
`else
    check_val("err_tied_low", 32'(err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
